clk_sel_ctrl: RTL and testbench

Single-clock control stage that drives the `sel` input of the downstream two-input clock selector (`sel=1` selects `clk1`, `sel=0` selects `clk2`). It accepts switch requests, gates the downstream clock off, changes `sel` only inside a quiet window, re-enables the clock, and then enforces a minimum dwell time before it accepts another switch. It runs on the always-on control clock and reports completion through an ack pulse and a busy flag.

---
 rtl/clk_sel_pkg.sv | 20 ++
 rtl/clk_sel_req_sync.sv | 33 +++
 rtl/clk_sel_ctrl.sv | 109 ++++++++++
 tb/tb_clk_sel_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/clk_sel_pkg.sv
// Shared types and constants for the clock-select sequencer.
// Holds the FSM state encoding, default timing and the reset value of sel.
package clk_sel_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    DWELL    = 2'd3
  } clk_sel_state_t;

  localparam int CLK_SEL_SETTLE_DEF = 4;
  localparam int CLK_SEL_DWELL_DEF  = 16;
  localparam logic CLK_SEL_RST_SEL  = 1'b0;

  function automatic int clk_sel_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_sel_req_sync.sv
// Request synchronizer: 2-flop sync of req/target plus registered rising-edge detect.
// Latency 3 cycles from the raw edge to req_pulse; no backpressure (one pulse per rising edge).
module clk_sel_req_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic req_async,
  input  logic target_async,
  output logic req_pulse,
  output logic target
);

  logic [1:0] req_meta;
  logic [1:0] tgt_meta;
  logic       req_prev;

  // target is registered alongside the pulse so both reach the FSM in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta  <= '0;
      tgt_meta  <= '0;
      req_prev  <= 1'b0;
      req_pulse <= 1'b0;
      target    <= 1'b0;
    end else begin
      req_meta  <= {req_meta[0], req_async};
      tgt_meta  <= {tgt_meta[0], target_async};
      req_prev  <= req_meta[1];
      req_pulse <= req_meta[1] & ~req_prev;
      target    <= tgt_meta[1];
    end
  end

endmodule

// File: rtl/clk_sel_ctrl.sv
// Clock-select sequencer: gate off, settle, flip sel, settle, ungate, dwell (CLK_SEL_REQ_SYNC_EN adds a req synchronizer, +3 cycles).
// Latency: ack at req+1+2*SETTLE_CYC; backpressure: requests while busy are dropped and flagged on req_drop.
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int SETTLE_CYC = CLK_SEL_SETTLE_DEF,
  parameter int DWELL_CYC  = CLK_SEL_DWELL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_req,
  input  logic sw_target,
  output logic sel,
  output logic clk_gate_en,
  output logic sw_ack,
  output logic busy,
  output logic req_drop
);

  localparam int CNT_MAX = clk_sel_max(SETTLE_CYC, DWELL_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);

  logic             req;
  logic             target;
  clk_sel_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

`ifdef CLK_SEL_REQ_SYNC_EN
  clk_sel_req_sync u_req_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_async    (sw_req),
    .target_async (sw_target),
    .req_pulse    (req),
    .target       (target)
  );
`else
  assign req    = sw_req;
  assign target = sw_target;
`endif

  always_comb begin
    cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
  end

  // sel only moves at the GATE_OFF->SWITCH boundary, a full settle window away from either gate edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= CLK_SEL_RST_SEL;
      clk_gate_en <= 1'b1;
      sw_ack      <= 1'b0;
      busy        <= 1'b0;
      req_drop    <= 1'b0;
    end else begin
      sw_ack   <= 1'b0;
      req_drop <= req && (state != IDLE);
      case (state)
        IDLE: begin
          if (req) begin
            if (target != sel) begin
              state       <= GATE_OFF;
              clk_gate_en <= 1'b0;
              busy        <= 1'b1;
              cnt         <= '0;
            end else begin
              sw_ack <= 1'b1;
            end
          end
        end
        GATE_OFF: begin
          if (cnt == SETTLE_LAST) begin
            sel   <= ~sel;
            state <= SWITCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        SWITCH: begin
          if (cnt == SETTLE_LAST) begin
            clk_gate_en <= 1'b1;
            sw_ack      <= 1'b1;
            state       <= DWELL;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DWELL: begin
          if (cnt == DWELL_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Scoreboard bench for clk_sel_ctrl: stimulus queues expected output events with their cycle,
// a negedge monitor pops one per observed event (any pulse, or a change of sel/clk_gate_en/busy).
module tb_clk_sel_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_req = 1'b0;
  logic sw_target = 1'b0;
  logic sel, clk_gate_en, sw_ack, busy, req_drop;

  clk_sel_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_req      (sw_req),
    .sw_target   (sw_target),
    .sel         (sel),
    .clk_gate_en (clk_gate_en),
    .sw_ack      (sw_ack),
    .busy        (busy),
    .req_drop    (req_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic sel;
    logic gate;
    logic ack;
    logic busy;
    logic drop;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  logic p_sel, p_gate, p_busy;
  bit   first = 1'b1;
  ev_t  e;

  always @(negedge clk) begin
    if (first || sel !== p_sel || clk_gate_en !== p_gate || busy !== p_busy ||
        sw_ack !== 1'b0 || req_drop !== 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event cyc=%0d got sel=%b gate=%b ack=%b busy=%b drop=%b, required no event",
                 cyc, sel, clk_gate_en, sw_ack, busy, req_drop);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.sel !== sel || e.gate !== clk_gate_en || e.ack !== sw_ack ||
            e.busy !== busy || e.drop !== req_drop) begin
          n_err++;
          $display("FAIL event got cyc=%0d sel=%b gate=%b ack=%b busy=%b drop=%b, required cyc=%0d sel=%b gate=%b ack=%b busy=%b drop=%b",
                   cyc, sel, clk_gate_en, sw_ack, busy, req_drop,
                   e.cyc, e.sel, e.gate, e.ack, e.busy, e.drop);
        end
      end
    end
    first  = 1'b0;
    p_sel  = sel;
    p_gate = clk_gate_en;
    p_busy = busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic s, input logic g, input logic a,
                      input logic b, input logic d);
    ev_t x;
    x.cyc = c; x.sel = s; x.gate = g; x.ack = a; x.busy = b; x.drop = d;
    exp_q.push_back(x);
  endtask

  task automatic pulse_req(input logic t);
    sw_target = t;
    sw_req    = 1'b1;
    step();
    sw_req    = 1'b0;
  endtask

  int n;

  initial begin
    // reset values are visible at the first negedge while rst_n is low
    push(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

`ifdef CLK_SEL_REQ_SYNC_EN
    n = cyc;
    push(n + 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_req(1'b0);
    repeat (8) step();

    // a 10-cycle level yields exactly one switch
    n = cyc;
    push(n + 4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(n + 8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(n + 12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push(n + 28, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sw_target = 1'b1;
    sw_req    = 1'b1;
    repeat (10) step();
    sw_req    = 1'b0;
    while (cyc < n + 40) step();
`else
    // same target: ack only
    n = cyc;
    push(n + 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_req(1'b0);
    repeat (4) step();

    // switch to clk1 with drops mid-dwell and on the last dwell cycle
    n = cyc;
    push(n + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(n + 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(n + 9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    pulse_req(1'b1);
    while (cyc < n + 12) step();
    push(n + 13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    pulse_req(1'b0);
    while (cyc < n + 24) step();
    push(n + 25, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_req(1'b0);
    // first IDLE cycle: accepted, switches back to clk2
    push(n + 26, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(n + 30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(n + 34, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push(n + 50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_req(1'b0);
    while (cyc < n + 55) step();

    // reset in the SWITCH phase
    n = cyc;
    push(n + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(n + 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_req(1'b1);
    while (cyc < n + 6) step();
    push(n + 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    n = cyc;
    push(n + 1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(n + 5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(n + 9,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push(n + 25, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_req(1'b1);
    while (cyc < n + 30) step();
`endif

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events got %0d outstanding, required 0 (next due cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
